ndp_stream_unit: RTL and testbench
==================================

Name: ndp_stream_unit

Overview:
- Next-generation near-data-processing compute unit. Tiles a SYS_HEIGHT x SYS_WIDTH grid of the existing systolic_array_with_buffer instances.
- Adds what the current unit lacks: a start/length command, a valid/ready operand feed, per-column-group enable masking, result capture, and a row-serialised valid/ready result drain in place of the full flat output bus.
- Sits between the memory-side operand streamer and the result writeback path.

Parameters:
- WIDTH, 16, element width in bits.
- IS_FLOAT, 1, 1 = float MAC, 0 = integer MAC; passed through to the arrays.
- EXP_BITS, 5, float exponent bits.
- FRAC_BITS, 10, float fraction bits.
- ARR_WIDTH, 4, PE columns per array.
- ARR_HEIGHT, 4, PE rows per array.
- SYS_WIDTH, 64, array columns (channel groups).
- SYS_HEIGHT, 1, array rows.
- KLEN_W, 16, width of the reduction-length counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command pulse; sampled only in IDLE.
- k_len  in  KLEN_W  number of operand beats (reduction depth).
- col_en  in  SYS_WIDTH  per-array-column enable; latched at start.
- SIMD_control  in  2  SIMD mode; latched at start and held for the whole operation.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- in_a  in  ARR_HEIGHT*SYS_HEIGHT*WIDTH  A column slice.
- in_b  in  ARR_WIDTH*SYS_WIDTH*WIDTH  B row slice.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accept.
- out_row  out  ARR_WIDTH*SYS_WIDTH*WIDTH  one result row (row r of the global C).
- out_last  out  1  high on the final row.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final row is accepted.

Behaviour:
- Reset (reset = 0): state IDLE, all counters 0. Outputs in_ready, out_valid, out_last, busy and done are 0; out_row is 0.
- Arrays are reset by the internal signal arr_rst = ~reset | clr_q, which is active-high into the instances.
- FSM states: IDLE, CLR, FEED, WAIT, DRAIN.
- IDLE:
  - start with k_len != 0: latch k_len, col_en and SIMD_control, then go to CLR.
  - start with k_len == 0: ignored; stay in IDLE with no done pulse.
- CLR: one cycle. clr_q = 1, clearing every array's accumulators and buffers; go to FEED.
- FEED:
  - in_ready = 1. Each accepted beat drives in_a/in_b into the arrays and increments beat_cnt.
  - On a non-accepted cycle the arrays receive all-zero operands. Bubbles are applied uniformly across all lanes, so alignment is preserved and sums are unaffected.
  - The cycle the beat with beat_cnt == k_len-1 is accepted: in_ready drops the next cycle and the state goes to WAIT.
- WAIT:
  - in_done_flag to every array is held at 1.
  - Wait for calc_all = AND over all arrays of (calc_done_flag | ~col_en_q[j]).
  - On calc_all, capture every array's out_c into the result register (one cycle) and go to DRAIN.
- Masking: disabled columns receive in_b = 0, their done flags are ignored, and their slice of the result is forced to 0.
- DRAIN:
  - row_cnt runs from 0 to ARR_HEIGHT*SYS_HEIGHT-1.
  - out_row = global row row_cnt, with element order j*ARR_WIDTH + l, l fastest.
  - out_valid is held until out_ready. out_row must stay stable while out_valid && !out_ready.
  - out_last = out_valid && row_cnt is the final row.
  - When the final row is accepted: pulse done and return to IDLE the next cycle.
- Latency: start → first in_ready = 2 cycles. calc_all → first out_valid = 1 cycle.
- Simultaneous events: start while busy is ignored. A reset assertion at any state aborts to IDLE immediately, with no done pulse and no out_valid.

Optional Feature:
- Macro: NDP_PERF_CNT_EN.
- When defined: adds 32-bit outputs perf_busy_cyc, perf_feed_stall and perf_drain_stall.
  - perf_busy_cyc counts cycles with busy = 1.
  - perf_feed_stall counts FEED cycles with !in_valid.
  - perf_drain_stall counts DRAIN cycles with out_valid && !out_ready.
  - Counters clear on start and saturate at all-ones.
- When undefined: the ports and logic are absent and functional behaviour is identical.

Decomposition:
- Shared package ndp_pkg: FSM state encoding (IDLE=0, CLR=1, FEED=2, WAIT=3, DRAIN=4), the SIMD_control encodings, and a ROW_BEATS = ARR_HEIGHT*SYS_HEIGHT localparam helper.
- One natural sub-module: ndp_drain_seq, covering the result register, row_cnt, the valid/ready output stage and out_last.

Test Plan:
- Setup: IS_FLOAT=0, WIDTH=16, 2x2 arrays, SYS_WIDTH=2, SYS_HEIGHT=1.
- Basic: start with k_len=3, col_en=2'b11; feed A = all 1, B = all 2, no bubbles → 2 rows; every element = 6; out_last on row 1; done pulses once.
- Bubbles: same command with in_valid low on alternate cycles → results identical (6); in_ready high throughout FEED.
- Mask: col_en=2'b01 → elements 2..3 of each row = 0; the done path does not hang on the disabled array.
- Backpressure: out_ready low for 5 cycles on row 0 → out_row stable, out_valid held; no row lost or duplicated.
- Boundaries: k_len=0 start → busy stays 0. Start while in DRAIN → ignored. Reset asserted in FEED → IDLE; a new k_len=1 command with A=3, B=4 then yields 12 everywhere.

Source files
------------

// File: rtl/ndp_pkg.sv
// rtl/ndp_pkg.sv - shared FSM encoding, SIMD modes and sizing helper for the NDP stream unit
package ndp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [1:0] SIMD_FULL = 2'd0;
  localparam logic [1:0] SIMD_HALF = 2'd1;
  localparam logic [1:0] SIMD_QUAD = 2'd2;

  // Number of global result rows drained per command (ROW_BEATS).
  function automatic int row_beats(input int arr_height, input int sys_height);
    return arr_height * sys_height;
  endfunction

endpackage

// File: rtl/ndp_stream_unit_if.sv
// rtl/ndp_stream_unit_if.sv - command, operand feed and result drain bundle of the NDP stream unit
interface ndp_stream_unit_if #(
  parameter int WIDTH      = 16,
  parameter int ARR_WIDTH  = 4,
  parameter int ARR_HEIGHT = 4,
  parameter int SYS_WIDTH  = 64,
  parameter int SYS_HEIGHT = 1,
  parameter int KLEN_W     = 16
);
  logic                                  start;
  logic [KLEN_W-1:0]                     k_len;
  logic [SYS_WIDTH-1:0]                  col_en;
  logic [1:0]                            SIMD_control;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [ARR_HEIGHT*SYS_HEIGHT*WIDTH-1:0] in_a;
  logic [ARR_WIDTH*SYS_WIDTH*WIDTH-1:0]  in_b;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [ARR_WIDTH*SYS_WIDTH*WIDTH-1:0]  out_row;
  logic                                  out_last;
  logic                                  busy;
  logic                                  done;

  modport master (
    output start, k_len, col_en, SIMD_control, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_row, out_last, busy, done
  );

  modport slave (
    input  start, k_len, col_en, SIMD_control, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_row, out_last, busy, done
  );
endinterface

// File: rtl/ndp_drain_seq.sv
// rtl/ndp_drain_seq.sv - result register and row-serialised valid/ready drain with out_last
module ndp_drain_seq #(
  parameter int ROW_W     = 64,
  parameter int ROW_BEATS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       capture,
  input  logic [ROW_BEATS*ROW_W-1:0] cap_rows,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [ROW_W-1:0]           out_row,
  output logic                       out_last,
  output logic                       final_acc
);
  localparam int CNT_W = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;

  logic [ROW_W-1:0] res_q [ROW_BEATS];
  logic [CNT_W-1:0] row_cnt;
  logic             valid_q;
  logic             is_last;

  assign is_last   = (row_cnt == CNT_W'(ROW_BEATS - 1));
  assign out_valid = valid_q;
  assign out_last  = valid_q && is_last;
  assign final_acc = valid_q && out_ready && is_last;
  // Row stays selected by row_cnt, so it is stable for as long as out_ready is held low.
  assign out_row   = valid_q ? res_q[row_cnt] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      row_cnt <= '0;
      for (int r = 0; r < ROW_BEATS; r++) res_q[r] <= '0;
    end else if (capture) begin
      valid_q <= 1'b1;
      row_cnt <= '0;
      for (int r = 0; r < ROW_BEATS; r++) res_q[r] <= cap_rows[r*ROW_W +: ROW_W];
    end else if (valid_q && out_ready) begin
      if (is_last) begin
        valid_q <= 1'b0;
        row_cnt <= '0;
      end else begin
        row_cnt <= row_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/systolic_array_with_buffer.sv
// rtl/systolic_array_with_buffer.sv - behavioural PE array: per-cell lane MAC, done flag one cycle behind in_done_flag
module systolic_array_with_buffer
  import ndp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int IS_FLOAT   = 1,
  parameter int EXP_BITS   = 5,
  parameter int FRAC_BITS  = 10,
  parameter int ARR_WIDTH  = 4,
  parameter int ARR_HEIGHT = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          SIMD_control,
  input  logic [ARR_HEIGHT*WIDTH-1:0]         in_a,
  input  logic [ARR_WIDTH*WIDTH-1:0]          in_b,
  input  logic                                in_done_flag,
  output logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0] out_c,
  output logic                                calc_done_flag
);
  localparam int H2 = WIDTH / 2;
  localparam int H4 = WIDTH / 4;

  if (IS_FLOAT != 0 && (1 + EXP_BITS + FRAC_BITS) != WIDTH) begin : g_fmt_check
    $error("float format does not fill WIDTH");
  end

  function automatic logic [WIDTH-1:0] lane_mac(input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       mode);
    logic [WIDTH-1:0] res;
    res = '0;
    case (mode)
      SIMD_FULL: res = acc + a * b;
      SIMD_HALF:
        for (int k = 0; k < 2; k++)
          res[k*H2 +: H2] = acc[k*H2 +: H2] + a[k*H2 +: H2] * b[k*H2 +: H2];
      SIMD_QUAD:
        for (int k = 0; k < 4; k++)
          res[k*H4 +: H4] = acc[k*H4 +: H4] + a[k*H4 +: H4] * b[k*H4 +: H4];
      default: res = acc + a * b;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_c          <= '0;
      calc_done_flag <= 1'b0;
    end else begin
      calc_done_flag <= in_done_flag;
      for (int r = 0; r < ARR_HEIGHT; r++)
        for (int l = 0; l < ARR_WIDTH; l++)
          out_c[(r*ARR_WIDTH+l)*WIDTH +: WIDTH] <=
            lane_mac(out_c[(r*ARR_WIDTH+l)*WIDTH +: WIDTH], in_a[r*WIDTH +: WIDTH],
                     in_b[l*WIDTH +: WIDTH], SIMD_control);
    end
  end
endmodule

// File: rtl/ndp_stream_unit.sv
// rtl/ndp_stream_unit.sv - tiled NDP compute unit with command FSM, masked feed and row drain
// Optional NDP_PERF_CNT_EN adds saturating busy/feed-stall/drain-stall counters.
module ndp_stream_unit
  import ndp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int IS_FLOAT   = 1,
  parameter int EXP_BITS   = 5,
  parameter int FRAC_BITS  = 10,
  parameter int ARR_WIDTH  = 4,
  parameter int ARR_HEIGHT = 4,
  parameter int SYS_WIDTH  = 64,
  parameter int SYS_HEIGHT = 1,
  parameter int KLEN_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  ndp_stream_unit_if.slave  bus
`ifdef NDP_PERF_CNT_EN
  ,
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_feed_stall,
  output logic [31:0]       perf_drain_stall
`endif
);
  localparam int ROW_BEATS = row_beats(ARR_HEIGHT, SYS_HEIGHT);
  localparam int ROW_W     = ARR_WIDTH * SYS_WIDTH * WIDTH;
  localparam int A_ARR_W   = ARR_HEIGHT * WIDTH;
  localparam int B_ARR_W   = ARR_WIDTH * WIDTH;
  localparam int C_ARR_W   = ARR_HEIGHT * ARR_WIDTH * WIDTH;

  state_t                   state, state_nx;
  logic [KLEN_W-1:0]        k_len_q, beat_cnt;
  logic [SYS_WIDTH-1:0]     col_en_q;
  logic [1:0]               simd_q;
  logic                     clr_q, done_q;
  logic                     start_acc, beat_acc, last_beat, calc_all, capture, final_acc;
  logic                     arr_rst, in_done;
  logic [A_ARR_W*SYS_HEIGHT-1:0] a_feed;
  logic [ROW_W-1:0]         b_feed;
  logic [SYS_HEIGHT*SYS_WIDTH-1:0] calc_done;
  logic [C_ARR_W-1:0]       arr_c [SYS_HEIGHT][SYS_WIDTH];
  logic [ROW_BEATS*ROW_W-1:0] cap_rows;

  assign arr_rst      = ~reset | clr_q;
  assign in_done      = (state == WAIT);
  assign beat_acc     = bus.in_valid && (state == FEED);
  assign last_beat    = (beat_cnt == k_len_q - KLEN_W'(1));
  assign bus.in_ready = (state == FEED);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;

  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (bus.start && bus.k_len != '0) begin
        start_acc = 1'b1;
        state_nx  = CLR;
      end
      CLR:   state_nx = FEED;
      FEED:  if (beat_acc && last_beat) state_nx = WAIT;
      WAIT:  if (calc_all) begin
        capture  = 1'b1;
        state_nx = DRAIN;
      end
      DRAIN: if (final_acc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      k_len_q  <= '0;
      col_en_q <= '0;
      simd_q   <= '0;
      beat_cnt <= '0;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      clr_q  <= start_acc;
      done_q <= final_acc;
      if (start_acc) begin
        k_len_q  <= bus.k_len;
        col_en_q <= bus.col_en;
        simd_q   <= bus.SIMD_control;
        beat_cnt <= '0;
      end else if (beat_acc) begin
        beat_cnt <= beat_cnt + KLEN_W'(1);
      end
    end
  end

  // Bubbles feed zeros to every lane at once, keeping all arrays in lockstep.
  always_comb begin
    a_feed = beat_acc ? bus.in_a : '0;
    b_feed = '0;
    for (int j = 0; j < SYS_WIDTH; j++)
      if (beat_acc && col_en_q[j]) b_feed[j*B_ARR_W +: B_ARR_W] = bus.in_b[j*B_ARR_W +: B_ARR_W];
  end

  always_comb begin
    calc_all = 1'b1;
    for (int i = 0; i < SYS_HEIGHT; i++)
      for (int j = 0; j < SYS_WIDTH; j++)
        calc_all &= calc_done[i*SYS_WIDTH+j] | ~col_en_q[j];
  end

  // Global row i*ARR_HEIGHT+r, element j*ARR_WIDTH+l; disabled columns read as zero.
  always_comb begin
    cap_rows = '0;
    for (int i = 0; i < SYS_HEIGHT; i++)
      for (int r = 0; r < ARR_HEIGHT; r++)
        for (int j = 0; j < SYS_WIDTH; j++)
          for (int l = 0; l < ARR_WIDTH; l++)
            if (col_en_q[j])
              cap_rows[(i*ARR_HEIGHT+r)*ROW_W + (j*ARR_WIDTH+l)*WIDTH +: WIDTH] =
                arr_c[i][j][(r*ARR_WIDTH+l)*WIDTH +: WIDTH];
  end

  for (genvar i = 0; i < SYS_HEIGHT; i++) begin : g_row
    for (genvar j = 0; j < SYS_WIDTH; j++) begin : g_col
      systolic_array_with_buffer #(
        .WIDTH(WIDTH), .IS_FLOAT(IS_FLOAT), .EXP_BITS(EXP_BITS), .FRAC_BITS(FRAC_BITS),
        .ARR_WIDTH(ARR_WIDTH), .ARR_HEIGHT(ARR_HEIGHT)
      ) u_arr (
        .clk            (clk),
        .rst            (arr_rst),
        .SIMD_control   (simd_q),
        .in_a           (a_feed[i*A_ARR_W +: A_ARR_W]),
        .in_b           (b_feed[j*B_ARR_W +: B_ARR_W]),
        .in_done_flag   (in_done),
        .out_c          (arr_c[i][j]),
        .calc_done_flag (calc_done[i*SYS_WIDTH+j])
      );
    end
  end

  ndp_drain_seq #(.ROW_W(ROW_W), .ROW_BEATS(ROW_BEATS)) u_drain (
    .clk       (clk),
    .rst_n     (reset),
    .capture   (capture),
    .cap_rows  (cap_rows),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_row   (bus.out_row),
    .out_last  (bus.out_last),
    .final_acc (final_acc)
  );

`ifdef NDP_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || start_acc) begin
      perf_busy_cyc    <= '0;
      perf_feed_stall  <= '0;
      perf_drain_stall <= '0;
    end else begin
      perf_busy_cyc    <= sat_inc(perf_busy_cyc, state != IDLE);
      perf_feed_stall  <= sat_inc(perf_feed_stall, state == FEED && !bus.in_valid);
      perf_drain_stall <= sat_inc(perf_drain_stall, bus.out_valid && !bus.out_ready);
    end
  end
`endif
endmodule

// File: tb/tb_ndp_stream_unit.sv
// tb/tb_ndp_stream_unit.sv - directed self-checking bench for ndp_stream_unit (2x2 arrays, 1x2 tiling)
module tb_ndp_stream_unit;
  localparam int W = 16, AW = 2, AH = 2, SW = 2, SH = 1, KW = 16;
  localparam int ROW_W = AW * SW * W;

  localparam logic [ROW_W-1:0] ROW_6    = {4{16'd6}};
  localparam logic [ROW_W-1:0] ROW_1    = {4{16'd1}};
  localparam logic [ROW_W-1:0] ROW_12   = {4{16'd12}};
  localparam logic [ROW_W-1:0] BP_R0    = {16'd12, 16'd9, 16'd6, 16'd3};
  localparam logic [ROW_W-1:0] BP_R1    = {16'd24, 16'd18, 16'd12, 16'd6};
  localparam logic [ROW_W-1:0] MASK_R0  = {16'd0, 16'd0, 16'd6, 16'd3};
  localparam logic [ROW_W-1:0] MASK_R1  = {16'd0, 16'd0, 16'd12, 16'd6};
  localparam logic [31:0]      A_ONES   = {2{16'd1}};
  localparam logic [31:0]      A_SEQ    = {16'd2, 16'd1};
  localparam logic [31:0]      A_THREE  = {2{16'd3}};
  localparam logic [63:0]      B_TWOS   = {4{16'd2}};
  localparam logic [63:0]      B_ONES   = {4{16'd1}};
  localparam logic [63:0]      B_SEQ    = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0]      B_FOUR   = {4{16'd4}};

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ndp_stream_unit_if #(.WIDTH(W), .ARR_WIDTH(AW), .ARR_HEIGHT(AH), .SYS_WIDTH(SW),
                       .SYS_HEIGHT(SH), .KLEN_W(KW)) bus ();

`ifdef NDP_PERF_CNT_EN
  logic [31:0] perf_busy_cyc, perf_feed_stall, perf_drain_stall;
`endif

  ndp_stream_unit #(.WIDTH(W), .IS_FLOAT(0), .EXP_BITS(5), .FRAC_BITS(10), .ARR_WIDTH(AW),
                    .ARR_HEIGHT(AH), .SYS_WIDTH(SW), .SYS_HEIGHT(SH), .KLEN_W(KW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef NDP_PERF_CNT_EN
    ,
    .perf_busy_cyc    (perf_busy_cyc),
    .perf_feed_stall  (perf_feed_stall),
    .perf_drain_stall (perf_drain_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle_bus;
    bus.start = 1'b0; bus.k_len = '0; bus.col_en = '0; bus.SIMD_control = 2'd0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
  endtask

  task automatic issue(input int k, input logic [1:0] col);
    bus.start = 1'b1; bus.k_len = KW'(k); bus.col_en = col; bus.SIMD_control = 2'd0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic feed(input int k, input logic [31:0] a, input logic [63:0] b, input bit bubbles,
                      output int sent, output int gaps);
    int cyc; bit seen; bit tog;
    cyc = 0; seen = 0; tog = 0; sent = 0; gaps = 0;
    while (sent < k && cyc < 200) begin
      if (bus.in_ready) seen = 1;
      else if (seen) gaps++;
      bus.in_valid = bubbles ? tog : 1'b1;
      bus.in_a = a; bus.in_b = b;
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.in_ready) tog = ~tog;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
  endtask

  task automatic drain(input int stall, output logic [ROW_W-1:0] r0, output logic [ROW_W-1:0] r1,
                       output int nrows, output int last_mask, output int unstable,
                       output int vgaps, output int dones);
    int cyc; int left; int extra; bit seen; bit holding; logic [ROW_W-1:0] held;
    cyc = 0; left = stall; extra = 0; seen = 0; holding = 0; held = '0;
    nrows = 0; last_mask = 0; unstable = 0; vgaps = 0; dones = 0; r0 = '0; r1 = '0;
    while (cyc < 100 && extra < 4) begin
      if (bus.done) dones++;
      if (bus.out_valid) begin
        seen = 1;
        if (holding && bus.out_row !== held) unstable++;
        if (left > 0) begin
          bus.out_ready = 1'b0; held = bus.out_row; holding = 1; left--;
        end else begin
          bus.out_ready = 1'b1; holding = 0;
          if (nrows == 0) r0 = bus.out_row;
          else if (nrows == 1) r1 = bus.out_row;
          if (bus.out_last) last_mask |= (1 << nrows);
          nrows++;
        end
      end else begin
        bus.out_ready = 1'b0;
        if (seen && nrows < 2) vgaps++;
      end
      if (nrows >= 2) extra++;
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    idle_bus();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.out_row !== '0) begin n_bad++; $display("FAIL reset_out_row: got %h want 0", bus.out_row); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int sent, gaps, nrows, lm, unst, vg, dn;
    logic [ROW_W-1:0] r0, r1;
    issue(3, 2'b11);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_clr: got %b want 0", bus.in_ready); end
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_lat: got %b want 1", bus.in_ready); end
    feed(3, A_ONES, B_TWOS, 1'b0, sent, gaps);
    n_cmp++; if (sent !== 3) begin n_bad++; $display("FAIL basic_sent: got %0d want 3", sent); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_drop: got %b want 0", bus.in_ready); end
    drain(0, r0, r1, nrows, lm, unst, vg, dn);
    n_cmp++; if (nrows !== 2) begin n_bad++; $display("FAIL basic_nrows: got %0d want 2", nrows); end
    n_cmp++; if (r0 !== ROW_6) begin n_bad++; $display("FAIL basic_row0: got %h want %h", r0, ROW_6); end
    n_cmp++; if (r1 !== ROW_6) begin n_bad++; $display("FAIL basic_row1: got %h want %h", r1, ROW_6); end
    n_cmp++; if (lm !== 2) begin n_bad++; $display("FAIL basic_last: got %0d want 2", lm); end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL basic_done: got %0d want 1", dn); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_bubbles;
    int sent, gaps, nrows, lm, unst, vg, dn;
    logic [ROW_W-1:0] r0, r1;
    issue(3, 2'b11);
    feed(3, A_ONES, B_TWOS, 1'b1, sent, gaps);
    n_cmp++; if (gaps !== 0) begin n_bad++; $display("FAIL bub_ready_gaps: got %0d want 0", gaps); end
    drain(0, r0, r1, nrows, lm, unst, vg, dn);
    n_cmp++; if (nrows !== 2) begin n_bad++; $display("FAIL bub_nrows: got %0d want 2", nrows); end
    n_cmp++; if (r0 !== ROW_6) begin n_bad++; $display("FAIL bub_row0: got %h want %h", r0, ROW_6); end
    n_cmp++; if (r1 !== ROW_6) begin n_bad++; $display("FAIL bub_row1: got %h want %h", r1, ROW_6); end
  endtask

  task automatic test_mask;
    int sent, gaps, nrows, lm, unst, vg, dn;
    logic [ROW_W-1:0] r0, r1;
    issue(3, 2'b01);
    feed(3, A_SEQ, B_SEQ, 1'b0, sent, gaps);
    drain(0, r0, r1, nrows, lm, unst, vg, dn);
    n_cmp++; if (nrows !== 2) begin n_bad++; $display("FAIL mask_nrows: got %0d want 2", nrows); end
    n_cmp++; if (r0 !== MASK_R0) begin n_bad++; $display("FAIL mask_row0: got %h want %h", r0, MASK_R0); end
    n_cmp++; if (r1 !== MASK_R1) begin n_bad++; $display("FAIL mask_row1: got %h want %h", r1, MASK_R1); end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL mask_done: got %0d want 1", dn); end
  endtask

  task automatic test_backpressure;
    int sent, gaps, nrows, lm, unst, vg, dn;
    logic [ROW_W-1:0] r0, r1;
    issue(3, 2'b11);
    feed(3, A_SEQ, B_SEQ, 1'b0, sent, gaps);
    drain(5, r0, r1, nrows, lm, unst, vg, dn);
    n_cmp++; if (unst !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes want 0", unst); end
    n_cmp++; if (vg !== 0) begin n_bad++; $display("FAIL bp_valid_held: got %0d gaps want 0", vg); end
    n_cmp++; if (nrows !== 2) begin n_bad++; $display("FAIL bp_nrows: got %0d want 2", nrows); end
    n_cmp++; if (r0 !== BP_R0) begin n_bad++; $display("FAIL bp_row0: got %h want %h", r0, BP_R0); end
    n_cmp++; if (r1 !== BP_R1) begin n_bad++; $display("FAIL bp_row1: got %h want %h", r1, BP_R1); end
    n_cmp++; if (lm !== 2) begin n_bad++; $display("FAIL bp_last: got %0d want 2", lm); end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL bp_done: got %0d want 1", dn); end
  endtask

  task automatic test_zero_len;
    issue(0, 2'b11);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy2: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL zero_done: got %b want 0", bus.done); end
  endtask

  task automatic test_start_in_drain;
    int sent, gaps, nrows, lm, unst, vg, dn, cyc;
    logic [ROW_W-1:0] r0, r1;
    issue(1, 2'b11);
    feed(1, A_ONES, B_ONES, 1'b0, sent, gaps);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL sid_valid: got %b want 1", bus.out_valid); end
    bus.start = 1'b1; bus.k_len = KW'(5); bus.col_en = 2'b11;
    @(negedge clk);
    bus.start = 1'b0;
    drain(0, r0, r1, nrows, lm, unst, vg, dn);
    n_cmp++; if (nrows !== 2) begin n_bad++; $display("FAIL sid_nrows: got %0d want 2", nrows); end
    n_cmp++; if (r0 !== ROW_1) begin n_bad++; $display("FAIL sid_row0: got %h want %h", r0, ROW_1); end
    n_cmp++; if (r1 !== ROW_1) begin n_bad++; $display("FAIL sid_row1: got %h want %h", r1, ROW_1); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL sid_idle: got %b want 0", bus.busy); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL sid_idle2: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_in_feed;
    int sent, gaps, nrows, lm, unst, vg, dn;
    logic [ROW_W-1:0] r0, r1;
    issue(4, 2'b11);
    feed(2, A_ONES, B_ONES, 1'b0, sent, gaps);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rif_in_feed: got %b want 1", bus.in_ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rif_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rif_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rif_valid: got %b want 0", bus.out_valid); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rif_done: got %b want 0", bus.done); end
    reset = 1'b1;
    @(negedge clk);
    issue(1, 2'b11);
    feed(1, A_THREE, B_FOUR, 1'b0, sent, gaps);
    drain(0, r0, r1, nrows, lm, unst, vg, dn);
    n_cmp++; if (nrows !== 2) begin n_bad++; $display("FAIL rif_nrows: got %0d want 2", nrows); end
    n_cmp++; if (r0 !== ROW_12) begin n_bad++; $display("FAIL rif_row0: got %h want %h", r0, ROW_12); end
    n_cmp++; if (r1 !== ROW_12) begin n_bad++; $display("FAIL rif_row1: got %h want %h", r1, ROW_12); end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL rif_done_new: got %0d want 1", dn); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_mask();
    test_backpressure();
    test_zero_len();
    test_start_in_drain();
    test_reset_in_feed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
